// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives a length-prefixed 8N1 byte stream and writes it into
// data memory as 32-bit little-endian words before the CPU is released.
// Optional feature: define UART_MEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte covering the length and data bytes.
module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        FR_LEN_LO,
        FR_LEN_HI,
        FR_DATA,
        FR_CSUM,
        FR_DONE,
        FR_ERROR
    } fr_state_t;
`else
    typedef enum logic [2:0] {
        FR_LEN_LO,
        FR_LEN_HI,
        FR_DATA,
        FR_DONE,
        FR_ERROR
    } fr_state_t;
`endif

    logic            r_rxMeta;
    logic            r_rxSync;
    logic            r_rxPrev;
    rx_state_t       r_rxState;
    rx_state_t       w_rxNext;
    logic [CW-1:0]   r_clkCnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_byteValid;
    logic            r_frameErr;
    logic            w_sampleBit;
    logic            w_byteDone;
    logic            w_frameErrNow;
    logic            w_startOk;

    fr_state_t       r_frState;
    fr_state_t       w_frNext;
    logic [7:0]      r_lenLo;
    logic [15:0]     r_lenWords;
    logic [15:0]     r_wordIdx;
    logic [1:0]      r_byteIdx;
    logic [23:0]     r_wordBuf;
    logic            r_memWrite;
    logic [31:0]     r_memAddr;
    logic [31:0]     r_memWdata;
    logic            r_lastWrite;
    logic [15:0]     r_wordCount;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            w_writeWord;
    logic            w_lastWord;
    logic            w_finishNow;
    logic            w_failNow;
    logic            w_terminal;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_xor;
`endif

    // Bring the asynchronous rx pin into the clock domain and keep the previous
    // synced value so a falling edge can be detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    // Bit receiver next-state: validate start bit at mid-bit, then sample each
    // data bit and the stop bit one bit period apart.
    always_comb begin
        w_rxNext      = r_rxState;
        w_sampleBit   = 1'b0;
        w_byteDone    = 1'b0;
        w_frameErrNow = 1'b0;
        w_startOk     = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (r_rxPrev && !r_rxSync) begin
                    w_rxNext = RX_START;
                end
            end
            RX_START: begin
                if (r_clkCnt == HALF_LAST) begin
                    if (!r_rxSync) begin
                        w_rxNext  = RX_DATA;
                        w_startOk = 1'b1;
                    end else begin
                        w_rxNext = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_sampleBit = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_rxNext = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_rxNext = RX_IDLE;
                    if (r_rxSync) begin
                        w_byteDone = 1'b1;
                    end else begin
                        w_frameErrNow = 1'b1;
                    end
                end
            end
            default: w_rxNext = RX_IDLE;
        endcase
    end

    // Bit receiver registers: state, bit-period counter, shift register and the
    // one-cycle byte-valid / framing-error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxState   <= RX_IDLE;
            r_clkCnt    <= '0;
            r_bitIdx    <= 3'd0;
            r_shift     <= 8'd0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_rxState   <= w_rxNext;
            r_byteValid <= w_byteDone;
            r_frameErr  <= w_frameErrNow;
            if (r_rxState == RX_IDLE || w_rxNext != r_rxState || w_sampleBit) begin
                r_clkCnt <= '0;
            end else begin
                r_clkCnt <= r_clkCnt + CW'(1);
            end
            if (w_startOk) begin
                r_bitIdx <= 3'd0;
            end else if (w_sampleBit) begin
                r_bitIdx <= r_bitIdx + 3'd1;
                r_shift  <= {r_rxSync, r_shift[7:1]};
            end
        end
    end

    assign w_terminal = (r_frState == FR_DONE) || (r_frState == FR_ERROR);

    // Frame next-state: length capture, word assembly, optional checksum and the
    // two terminal states; a framing error anywhere before the end is fatal.
    always_comb begin
        w_frNext    = r_frState;
        w_writeWord = 1'b0;
        w_lastWord  = 1'b0;
        w_finishNow = 1'b0;
        w_failNow   = 1'b0;
        if (r_frameErr && !w_terminal) begin
            w_frNext  = FR_ERROR;
            w_failNow = 1'b1;
        end else if (r_byteValid) begin
            case (r_frState)
                FR_LEN_LO: w_frNext = FR_LEN_HI;
                FR_LEN_HI: begin
                    if ({r_shift, r_lenLo} == 16'd0) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                        w_frNext = FR_CSUM;
`else
                        w_frNext    = FR_DONE;
                        w_finishNow = 1'b1;
`endif
                    end else begin
                        w_frNext = FR_DATA;
                    end
                end
                FR_DATA: begin
                    if (r_byteIdx == 2'd3) begin
                        w_writeWord = 1'b1;
                        if (r_wordIdx == r_lenWords - 16'd1) begin
                            w_lastWord = 1'b1;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                            w_frNext = FR_CSUM;
`else
                            w_frNext = FR_DONE;
`endif
                        end
                    end
                end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                FR_CSUM: begin
                    if (r_shift == r_xor) begin
                        w_frNext    = FR_DONE;
                        w_finishNow = 1'b1;
                    end else begin
                        w_frNext  = FR_ERROR;
                        w_failNow = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Frame registers: length, word assembly, the registered memory write and
    // the word counter that follows each write by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frState   <= FR_LEN_LO;
            r_lenLo     <= 8'd0;
            r_lenWords  <= 16'd0;
            r_wordIdx   <= 16'd0;
            r_byteIdx   <= 2'd0;
            r_wordBuf   <= 24'd0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= BASE_ADDR;
            r_memWdata  <= 32'd0;
            r_lastWrite <= 1'b0;
            r_wordCount <= 16'd0;
        end else begin
            r_frState  <= w_frNext;
            r_memWrite <= w_writeWord;
            if (r_byteValid && !r_frameErr) begin
                if (r_frState == FR_LEN_LO) begin
                    r_lenLo <= r_shift;
                end
                if (r_frState == FR_LEN_HI) begin
                    r_lenWords <= {r_shift, r_lenLo};
                end
                if (r_frState == FR_DATA) begin
                    r_byteIdx <= r_byteIdx + 2'd1;
                    case (r_byteIdx)
                        2'd0:    r_wordBuf[7:0]   <= r_shift;
                        2'd1:    r_wordBuf[15:8]  <= r_shift;
                        2'd2:    r_wordBuf[23:16] <= r_shift;
                        default: ;
                    endcase
                end
            end
            if (w_writeWord) begin
                r_memWdata  <= {r_shift, r_wordBuf};
                r_memAddr   <= BASE_ADDR + {14'd0, r_wordIdx, 2'b00};
                r_lastWrite <= w_lastWord;
                r_wordIdx   <= r_wordIdx + 16'd1;
            end
            if (r_memWrite) begin
                r_wordCount <= r_wordCount + 16'd1;
            end
        end
    end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    // Running XOR over both length bytes and every data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xor <= 8'd0;
        end else if (r_byteValid && !r_frameErr &&
                     (r_frState == FR_LEN_LO || r_frState == FR_LEN_HI || r_frState == FR_DATA)) begin
            r_xor <= r_xor ^ r_shift;
        end
    end
`endif

    // Status flags: busy from the first accepted start bit, falling on the same
    // edge that the sticky done or error flag rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (w_failNow) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_finishNow || (r_memWrite && r_lastWrite && !CSUM_EN)) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
        end else if (w_startOk && !w_terminal && !r_done && !r_error) begin
            r_busy <= 1'b1;
        end
    end

    assign mem_write  = r_memWrite;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_wordCount;

endmodule
